// File: rtl/ram_port_master_if.sv
// Request, response and RAM-pin bundle for one RAM port front end.
// The master modport is the front-end view; slave is the requester/RAM side.
interface ram_port_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_q,
    input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_port_master.sv
// Requester-side front end for one port of a synchronous RAM: credit-checked
// request acceptance and an in-order response FIFO fed from the registered RAM output.
module ram_port_master_chk #(
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input logic             clock,
  input logic             reset,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count == CNT_W'(RESP_DEPTH))));

  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    !(pop && (count == CNT_W'(0))));
endmodule

module ram_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RESP_DEPTH = 2
) (
  input logic               clock,
  input logic               reset,
  ram_port_master_if.master bus
);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 2);

  logic [DATA_WIDTH-1:0] fifo_mem_r [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  rd_pending_r;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ready_s;
  logic [CNT_W-1:0]      used_s;
  logic [CNT_W-1:0]      credit_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Credit check: a pop this cycle frees a slot for a request this cycle.
  always_comb begin
    used_s   = count_r + CNT_W'(rd_pending_r);
    pop_s    = (count_r != CNT_W'(0)) & bus.rsp_ready;
    credit_s = used_s - CNT_W'(pop_s);
    ready_s  = !reset && (credit_s < CNT_W'(RESP_DEPTH));
    accept_s = bus.req_valid & ready_s;
    push_s   = rd_pending_r;
  end

  assign bus.req_ready = ready_s;
  assign bus.ram_addr  = bus.req_addr;
  assign bus.ram_wdata = bus.req_wdata;
  assign bus.ram_we    = accept_s & bus.req_we;
  assign bus.rsp_valid = (count_r != CNT_W'(0));
  assign bus.rsp_rdata = fifo_mem_r[rd_ptr_r];

  // Pointer, occupancy and in-flight read tracking; reset drops any pending read.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      count_r      <= CNT_W'(0);
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= accept_s & !bus.req_we;
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Response storage captures ram_q the cycle after a read is accepted.
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      fifo_mem_r[wr_ptr_r] <= bus.ram_q;
    end
  end

  ram_port_master_chk #(.RESP_DEPTH(RESP_DEPTH), .CNT_W(CNT_W)) u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_ram_port_master.sv
// Directed-vector and scoreboard bench for ram_port_master with a behavioural 64x8 RAM port.
module tb_ram_port_master;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ram_port_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // RAM port model: registered read, q holds during writes.
  logic [DW-1:0] ram_mem [64];
  always @(posedge clock) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    else            bus.ram_q <= ram_mem[bus.ram_addr];
  end

  typedef struct {
    logic          rst;
    logic          vld;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_rdy;
    logic          e_we;
    logic          e_rv;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t          vecs [14];
  logic [DW-1:0] model_mem [64];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge, then settle before comparing.
  task automatic drive(input logic rst, input logic vld, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    @(negedge clock);
    reset         = rst;
    bus.req_valid = vld;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #1;
  endtask

  initial begin
    int acc;
    int nxt;
    logic          v, w, r, exp_rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 6'd5;
    bus.req_wdata = 8'hA5;
    bus.rsp_ready = 1'b1;

    // Reset with a pending write offer, write-then-read latency, and a stalled response.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 6'd5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 6'd5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 6'd5, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 6'd6, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'd6, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rr);
      chk($sformatf("vec%0d req_ready", i), bus.req_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d ram_we", i), bus.ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d rsp_valid", i), bus.rsp_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("vec%0d rsp_rdata", i), bus.rsp_rdata, vecs[i].e_rd);
    end

    // Back-to-back reads of a preloaded block with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, AW'(i), 8'h10 + DW'(i), 1'b1);
      chk("preload ram_we", bus.ram_we, 1'b1);
    end
    for (int j = 0; j < 10; j++) begin
      if (j < 8) drive(1'b0, 1'b1, 1'b0, AW'(j), 8'h00, 1'b1);
      else       drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      if (j < 8) chk($sformatf("burst ready %0d", j), bus.req_ready, 1'b1);
      if (j < 2) chk($sformatf("burst early valid %0d", j), bus.rsp_valid, 1'b0);
      else begin
        chk($sformatf("burst valid %0d", j), bus.rsp_valid, 1'b1);
        chk($sformatf("burst data %0d", j), bus.rsp_rdata, 8'h10 + DW'(j - 2));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("burst drained", bus.rsp_valid, 1'b0);

    // Back-pressure: only RESP_DEPTH reads may be in flight.
    acc = 0;
    nxt = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, AW'(nxt), 8'h00, 1'b0);
      if (bus.req_ready) begin
        acc++;
        nxt++;
      end
    end
    chk("bp accepted", acc, DEPTH);
    chk("bp ready low", bus.req_ready, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      if (bus.rsp_valid) got_q.push_back(bus.rsp_rdata);
    end
    chk("bp count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp data0", got_q[0], 8'h10);
      chk("bp data1", got_q[1], 8'h11);
    end

    // Reset the cycle after a read accept: its data must never surface.
    drive(1'b0, 1'b1, 1'b0, 6'd7, 8'h00, 1'b1);
    chk("rst-read accept", bus.req_ready, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("rst-read ready", bus.req_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
      chk($sformatf("rst-read no valid %0d", k), bus.rsp_valid, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0, 6'd4, 8'h00, 1'b1);
    chk("post-rst accept", bus.req_ready, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("post-rst early", bus.rsp_valid, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    chk("post-rst valid", bus.rsp_valid, 1'b1);
    chk("post-rst data", bus.rsp_rdata, 8'h14);

    // Random traffic against a memory model and an expected-response queue.
    for (int i = 0; i < 64; i++) begin
      d = DW'(i * 37 + 11);
      drive(1'b0, 1'b1, 1'b1, AW'(i), d, 1'b1);
      model_mem[i] = d;
    end
    for (int n = 0; n < 1008; n++) begin
      v = (n < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 63));
      d = DW'($urandom_range(0, 255));
      r = (n < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(1'b0, v, w, a, d, r);
      exp_rdy = ((exp_q.size() - ((bus.rsp_valid && r) ? 1 : 0)) < DEPTH);
      chk("rnd req_ready", bus.req_ready, exp_rdy);
      if (bus.rsp_valid && r) begin
        if (exp_q.size() == 0) chk("rnd spurious rsp", 1'b1, 1'b0);
        else                   chk("rnd rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
      end
      if (v && bus.req_ready) begin
        if (w) model_mem[a] = d;
        else   exp_q.push_back(model_mem[a]);
      end
    end
    chk("rnd all responses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
